// File: rtl/signature_analyzer_pkg.sv
// Shared types and constants for the signature analyzer: FSM states, CRC-16-CCITT
// polynomial, default seed and the single-step SISR update.
package signature_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_COMPACT = 2'd2,
    ST_DONE    = 2'd3
  } sa_state_e;

  localparam logic [15:0] SA_POLY         = 16'h1021;
  localparam logic [15:0] SA_SEED_DEFAULT = 16'h0000;

  // One compaction step of x^16+x^12+x^5+1 with the serial input folded into the feedback.
  function automatic logic [15:0] sisr16_step(input logic [15:0] sig, input logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? SA_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/signature_analyzer_sisr16.sv
// 16-bit single-input signature register with enable and synchronous seed load.
// Load has priority over enable.
module sisr16
  import signature_analyzer_pkg::*;
#(
  parameter logic [15:0] SEED = SA_SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  input  logic        load_i,
  input  logic        din_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = sisr16_step(sig_q, din_i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/signature_analyzer.sv
// Scan-response signature analyzer: discards FLUSH_CYCLES shifts, compacts BIT_COUNT bits.
// Define SIGNATURE_ANALYZER_COMPARE_EN to register a GOLDEN comparison into pass.
module signature_analyzer
  import signature_analyzer_pkg::*;
#(
  parameter int          SIG_BITS     = 16,
  parameter logic [15:0] SEED         = SA_SEED_DEFAULT,
  parameter int          FLUSH_CYCLES = 8,
  parameter int          BIT_COUNT    = 64,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                scan_out,
  input  logic                start,
  output logic [SIG_BITS-1:0] signature,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int BIT_W   = $clog2(BIT_COUNT + 1);

  sa_state_e          state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sisr_en;
  logic               sisr_load;
  logic [15:0]        sig_w;
`ifdef SIGNATURE_ANALYZER_COMPARE_EN
  logic               pass_q, pass_d;
`endif

  sisr16 #(
    .SEED (SEED)
  ) u_sisr (
    .clock  (clock),
    .reset  (reset),
    .en_i   (sisr_en),
    .load_i (sisr_load),
    .din_i  (scan_out),
    .sig_o  (sig_w)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sisr_en     = 1'b0;
    sisr_load   = 1'b0;
`ifdef SIGNATURE_ANALYZER_COMPARE_EN
    pass_d      = pass_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sisr_load   = 1'b1;
          flush_cnt_d = '0;
          bit_cnt_d   = '0;
`ifdef SIGNATURE_ANALYZER_COMPARE_EN
          pass_d      = 1'b0;
`endif
          state_d     = (FLUSH_CYCLES == 0) ? ST_COMPACT : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (mode) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_d == FLUSH_W'(FLUSH_CYCLES)) begin
            state_d = ST_COMPACT;
          end
        end
      end
      ST_COMPACT: begin
        if (mode) begin
          sisr_en   = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == BIT_W'(BIT_COUNT)) begin
            state_d = ST_DONE;
`ifdef SIGNATURE_ANALYZER_COMPARE_EN
            // Compare the value the register takes on this same edge.
            pass_d  = (sisr16_step(sig_w, scan_out) == GOLDEN);
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FLUSH) || (state_d == ST_COMPACT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SIGNATURE_ANALYZER_COMPARE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  assign signature = sig_w;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
